// File: rtl/lcd12864_pkg.sv
// Shared types and constants for the ST7920-style 12864 LCD bus responder:
// FSM states, the captured bus word, basic-instruction opcodes and row bases.
package lcd12864_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CLEAR,
        ST_BUSY
    } state_t;

    // One sample of the parallel bus, carried through the synchronizer as a unit.
    typedef struct packed {
        logic       en;
        logic       rs;
        logic       rw;
        logic [7:0] dat;
    } bus_t;

    // Decoded basic instruction.
    typedef enum logic [3:0] {
        OP_NOP,
        OP_CLEAR,
        OP_HOME,
        OP_ENTRY,
        OP_DISPCTL,
        OP_SHIFT,
        OP_FUNCSET,
        OP_CGRAM,
        OP_DDRAM
    } op_t;

    // An opcode matches when (dat & *_MASK) == value.
    localparam logic [7:0] CMD_DDRAM_MASK   = 8'h80;
    localparam logic [7:0] CMD_DDRAM        = 8'h80;
    localparam logic [7:0] CMD_CGRAM_MASK   = 8'hC0;
    localparam logic [7:0] CMD_CGRAM        = 8'h40;
    localparam logic [7:0] CMD_FUNCSET_MASK = 8'hE0;
    localparam logic [7:0] CMD_FUNCSET      = 8'h20;
    localparam logic [7:0] CMD_SHIFT_MASK   = 8'hF0;
    localparam logic [7:0] CMD_SHIFT        = 8'h10;
    localparam logic [7:0] CMD_DISPCTL_MASK = 8'hF8;
    localparam logic [7:0] CMD_DISPCTL      = 8'h08;
    localparam logic [7:0] CMD_ENTRY_MASK   = 8'hFC;
    localparam logic [7:0] CMD_ENTRY        = 8'h04;
    localparam logic [7:0] CMD_HOME_MASK    = 8'hFE;
    localparam logic [7:0] CMD_HOME         = 8'h02;
    localparam logic [7:0] CMD_CLEAR_MASK   = 8'hFF;
    localparam logic [7:0] CMD_CLEAR        = 8'h01;

    // DDRAM set-address values for the start of each display row.
    localparam logic [7:0] LINE0 = 8'h80;
    localparam logic [7:0] LINE1 = 8'h90;
    localparam logic [7:0] LINE2 = 8'h88;
    localparam logic [7:0] LINE3 = 8'h98;

    // Byte written to every DDRAM location by the clear instruction (ASCII space).
    localparam logic [7:0] CLEAR_FILL = 8'h20;

    // First match from the MSB wins, mirroring the controller's priority decode.
    function automatic op_t decode(input logic [7:0] dat);
        if ((dat & CMD_DDRAM_MASK) == CMD_DDRAM)     return OP_DDRAM;
        if ((dat & CMD_CGRAM_MASK) == CMD_CGRAM)     return OP_CGRAM;
        if ((dat & CMD_FUNCSET_MASK) == CMD_FUNCSET) return OP_FUNCSET;
        if ((dat & CMD_SHIFT_MASK) == CMD_SHIFT)     return OP_SHIFT;
        if ((dat & CMD_DISPCTL_MASK) == CMD_DISPCTL) return OP_DISPCTL;
        if ((dat & CMD_ENTRY_MASK) == CMD_ENTRY)     return OP_ENTRY;
        if ((dat & CMD_HOME_MASK) == CMD_HOME)       return OP_HOME;
        if ((dat & CMD_CLEAR_MASK) == CMD_CLEAR)     return OP_CLEAR;
        return OP_NOP;
    endfunction

endpackage

// File: rtl/lcd12864_ddram.sv
// 64x8 DDRAM image: one synchronous write port for the bus side and one
// registered read port for the renderer. A same-cycle read of the address
// being written returns the old contents.
module lcd12864_ddram (
    input  logic       clk,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [7:0] wdata,
    input  logic [5:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [64];

    // Write and registered read share one edge; the read sees the pre-write value.
    // NOTE: the array has no reset on purpose -- clearing RAM is an instruction,
    // not a reset side effect, and a reset branch would stop RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/lcd12864_bus_responder.sv
// Device side of the ST7920-style 8-bit LCD bus: synchronizes the strobe,
// decodes basic instructions, owns the DDRAM image and display-control bits.
// Optional macro READBACK_EN enables status/data reads on lcd_dat_out.
module lcd12864_bus_responder
    import lcd12864_pkg::*;
#(
    parameter int BUSY_CYCLES = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_dat_in,
    output logic [7:0] lcd_dat_out,
    output logic       lcd_dat_oe,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       ext_mode,
    output logic       busy,
    output logic       cmd_drop,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data
);

    localparam int BW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

    bus_t [SYNC_STAGES-1:0] sync_q;
    bus_t                   bus_s;
    logic                   en_d;
    logic                   fall;

    state_t        state, state_d;
    op_t           op;
    logic          cap_rs;
    logic [7:0]    cap_dat;
    logic [4:0]    ac;
    logic          byte_sel;
    logic          inc;
    logic [5:0]    clr_cnt;
    logic [BW-1:0] bcnt;

    logic          accept, drop;
    logic          ram_we;
    logic [5:0]    ram_addr;
    logic [7:0]    ram_wdata;

    assign bus_s = sync_q[SYNC_STAGES-1];
    assign fall  = en_d & ~bus_s.en;
    assign op    = decode(cap_dat);
    assign busy  = (state != ST_IDLE);

    // Bus synchronizer chain; every bus signal sees the same depth so rs/rw/dat
    // line up with the synced strobe edge.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            en_d   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {lcd_en, lcd_rs, lcd_rw, lcd_dat_in}};
            en_d   <= bus_s.en;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, strobe acceptance and RAM write-port steering.
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        drop      = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {ac, byte_sel};
        ram_wdata = cap_dat;
        unique case (state)
            ST_IDLE: begin
                if (fall) begin
                    if (bus_s.rw) begin
`ifdef READBACK_EN
                        drop = 1'b0;  // reads are served live while en is high
`else
                        drop = 1'b1;
`endif
                    end else if (ext_mode && !bus_s.rs && decode(bus_s.dat) != OP_FUNCSET) begin
                        drop = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                ram_we = cap_rs;
                if (!cap_rs && op == OP_CLEAR) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = (BUSY_CYCLES > 0) ? ST_BUSY : ST_IDLE;
                end
            end
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt;
                ram_wdata = CLEAR_FILL;
                if (clr_cnt == 6'd63) begin
                    state_d = (BUSY_CYCLES > 0) ? ST_BUSY : ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bcnt == '0) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        if (fall && state != ST_IDLE) begin
            drop = 1'b1;
        end
    end

    // Address counter, display-control bits and the clear/busy counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_rs    <= 1'b0;
            cap_dat   <= 8'h00;
            ac        <= 5'd0;
            byte_sel  <= 1'b0;
            inc       <= 1'b1;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            blink_on  <= 1'b0;
            ext_mode  <= 1'b0;
            clr_cnt   <= 6'd0;
            bcnt      <= '0;
            cmd_drop  <= 1'b0;
        end else begin
            cmd_drop <= drop;
            if (accept) begin
                cap_rs  <= bus_s.rs;
                cap_dat <= bus_s.dat;
            end
            if (state == ST_EXEC) begin
                clr_cnt <= 6'd0;
                bcnt    <= BW'(BUSY_CYCLES - 1);
                if (cap_rs) begin
                    byte_sel <= ~byte_sel;
                    if (inc && byte_sel) begin
                        ac <= ac + 5'd1;
                    end else if (!inc && !byte_sel) begin
                        ac <= ac - 5'd1;
                    end
                end else begin
                    case (op)
                        OP_DDRAM: begin
                            ac       <= cap_dat[4:0];
                            byte_sel <= 1'b0;
                        end
                        OP_FUNCSET: ext_mode <= cap_dat[2];
                        OP_DISPCTL: {disp_on, cursor_on, blink_on} <= cap_dat[2:0];
                        OP_ENTRY:   inc <= cap_dat[1];
                        OP_HOME: begin
                            ac       <= 5'd0;
                            byte_sel <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 6'd1;
                if (clr_cnt == 6'd63) begin
                    ac       <= 5'd0;
                    byte_sel <= 1'b0;
                    inc      <= 1'b1;
                end
            end
            if (state == ST_BUSY) begin
                bcnt <= bcnt - BW'(1);
            end
        end
    end

`ifdef READBACK_EN
    assign lcd_dat_oe  = bus_s.en & bus_s.rw;
    assign lcd_dat_out = (lcd_dat_oe && !bus_s.rs) ? {busy, 1'b0, ac, byte_sel} : 8'h00;
`else
    assign lcd_dat_oe  = 1'b0;
    assign lcd_dat_out = 8'h00;
`endif

    // A write landing in the reset cycle is suppressed so an aborted clear
    // leaves the untouched bytes intact.
    lcd12864_ddram u_ddram (
        .clk   (clk),
        .we    (ram_we && rst_n),
        .waddr (ram_addr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_lcd12864_bus_responder.sv
// Directed bench for lcd12864_bus_responder: init sequence, row writes,
// address wrap, decrement mode, clear with busy/drop, ext mode, reads and
// reset during clear. Expected DDRAM contents are kept in a local image.
module tb_lcd12864_bus_responder;
    import lcd12864_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_en = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic [7:0] lcd_dat_in = 8'h00;
    logic [7:0] lcd_dat_out;
    logic       lcd_dat_oe;
    logic       disp_on, cursor_on, blink_on, ext_mode, busy, cmd_drop;
    logic [5:0] rd_addr = 6'd0;
    logic [7:0] rd_data;

    int errors = 0;
    int checks = 0;
    int busy_cnt = 0;
    int drop_cnt = 0;
    logic [7:0] model [64];

    lcd12864_bus_responder #(.BUSY_CYCLES(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_dat_in(lcd_dat_in), .lcd_dat_out(lcd_dat_out), .lcd_dat_oe(lcd_dat_oe),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .ext_mode(ext_mode), .busy(busy), .cmd_drop(cmd_drop),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Count busy cycles and drop pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (cmd_drop === 1'b1) drop_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic strobe(input logic rs, input logic [7:0] dat);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b0; lcd_dat_in = dat; lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        lcd_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy never cleared, got %b want 0", tag, busy);
        end
    endtask

    task automatic cmd(input logic [7:0] dat);
        strobe(1'b0, dat);
        wait_idle($sformatf("cmd_%02h", dat));
    endtask

    task automatic data_wr(input logic [7:0] dat, input logic [5:0] exp_addr);
        strobe(1'b1, dat);
        wait_idle($sformatf("data_%02h", dat));
        model[exp_addr] = dat;
    endtask

    task automatic read_byte(input logic [5:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = a;
        @(posedge clk);
        #1 d = rd_data;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({disp_on, cursor_on, blink_on, ext_mode, busy, cmd_drop, lcd_dat_oe} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {disp_on, cursor_on, blink_on, ext_mode, busy, cmd_drop, lcd_dat_oe});
        end
        checks++;
        if (lcd_dat_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_dat_out: got %02h want 00", lcd_dat_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_init;
        int d0 = drop_cnt;
        cmd(8'h30); cmd(8'h0C); cmd(8'h06); cmd(8'h30);
        checks++;
        if ({disp_on, cursor_on, blink_on, ext_mode} !== 4'b1000) begin
            errors++;
            $display("FAIL init_dcbx: got %b want 1000", {disp_on, cursor_on, blink_on, ext_mode});
        end
        checks++;
        if (drop_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL init_drop: got %0d pulses want 0", drop_cnt - d0);
        end
    endtask

    task automatic test_clear;
        int b0 = busy_cnt;
        int d0 = drop_cnt;
        logic [7:0] d;
        strobe(1'b0, CMD_CLEAR);
        strobe(1'b0, 8'h0F);    // lands while the clear is still running
        wait_idle("clear");
        checks++;
        if (busy_cnt - b0 !== 73) begin
            errors++;
            $display("FAIL clear_busy_len: got %0d cycles want 73", busy_cnt - b0);
        end
        checks++;
        if (drop_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL clear_drop: got %0d pulses want 1", drop_cnt - d0);
        end
        checks++;
        if ({disp_on, cursor_on, blink_on} !== 3'b100) begin
            errors++;
            $display("FAIL clear_dcb: got %b want 100", {disp_on, cursor_on, blink_on});
        end
        for (int a = 0; a < 64; a++) model[a] = CLEAR_FILL;
        for (int a = 0; a < 64; a++) begin
            read_byte(6'(a), d);
            checks++;
            if (d !== model[a]) begin
                errors++;
                $display("FAIL clear_mem[%02h]: got %02h want %02h", a, d, model[a]);
            end
        end
    endtask

    task automatic test_row_write;
        logic [7:0] d;
        cmd(LINE1);
        for (int i = 0; i < 16; i++) data_wr(8'(8'h41 + i), 6'(6'h20 + i));
        data_wr(8'h55, 6'h30);   // ac=0x18, byte_sel=0 after 16 bytes
        for (int a = 8'h20; a <= 8'h30; a++) begin
            read_byte(6'(a), d);
            checks++;
            if (d !== model[a]) begin
                errors++;
                $display("FAIL row_mem[%02h]: got %02h want %02h", a, d, model[a]);
            end
        end
        // Renderer port is registered: changing rd_addr has no effect until the next edge.
        read_byte(6'h20, d);
        rd_addr = 6'h21;
        #2;
        checks++;
        if (rd_data !== 8'h41) begin
            errors++;
            $display("FAIL rd_latency_hold: got %02h want 41", rd_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd_data !== 8'h42) begin
            errors++;
            $display("FAIL rd_latency_next: got %02h want 42", rd_data);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] d;
        logic [5:0] addrs [5];
        addrs = '{6'h3E, 6'h3F, 6'h00, 6'h01, 6'h02};
        cmd(8'h9F);
        data_wr(8'hA0, 6'h3E); data_wr(8'hA1, 6'h3F);
        data_wr(8'hA2, 6'h00); data_wr(8'hA3, 6'h01);
        data_wr(8'hB4, 6'h02);   // ac=0x01 after the wrap
        for (int i = 0; i < 5; i++) begin
            read_byte(addrs[i], d);
            checks++;
            if (d !== model[addrs[i]]) begin
                errors++;
                $display("FAIL wrap_mem[%02h]: got %02h want %02h", addrs[i], d, model[addrs[i]]);
            end
        end
    endtask

    task automatic test_entry_rows;
        logic [7:0] d;
        logic [5:0] addrs [5];
        addrs = '{6'h00, 6'h3F, 6'h3E, 6'h10, 6'h30};
        cmd(LINE0);
        cmd(8'h04);              // decrement mode
        data_wr(8'hC0, 6'h00);   // ac 0 -> 31, byte_sel 1
        data_wr(8'hC1, 6'h3F);
        data_wr(8'hC2, 6'h3E);
        cmd(8'h06);
        cmd(CMD_HOME);
        data_wr(8'hD0, 6'h00);
        cmd(LINE2);
        data_wr(8'hE0, 6'h10);
        cmd(LINE3);
        data_wr(8'hE1, 6'h30);
        for (int i = 0; i < 5; i++) begin
            read_byte(addrs[i], d);
            checks++;
            if (d !== model[addrs[i]]) begin
                errors++;
                $display("FAIL entry_mem[%02h]: got %02h want %02h", addrs[i], d, model[addrs[i]]);
            end
        end
    endtask

    task automatic test_ext_mode;
        int b0, d0;
        cmd(8'h34);
        checks++;
        if (ext_mode !== 1'b1) begin
            errors++;
            $display("FAIL ext_set: got %b want 1", ext_mode);
        end
        b0 = busy_cnt; d0 = drop_cnt;
        strobe(1'b0, 8'h0F);
        checks++;
        if (drop_cnt - d0 !== 1 || busy_cnt - b0 !== 0) begin
            errors++;
            $display("FAIL ext_drop: got drops=%0d busy=%0d want drops=1 busy=0",
                     drop_cnt - d0, busy_cnt - b0);
        end
        checks++;
        if (blink_on !== 1'b0) begin
            errors++;
            $display("FAIL ext_blink: got %b want 0", blink_on);
        end
        cmd(8'h30);
        checks++;
        if (ext_mode !== 1'b0) begin
            errors++;
            $display("FAIL ext_clear: got %b want 0", ext_mode);
        end
    endtask

    task automatic test_read;
        int b0, d0;
        logic oe_seen;
        logic [7:0] out_seen;
        logic exp_oe;
        logic [7:0] exp_out;
        int exp_drop;
`ifdef READBACK_EN
        exp_oe = 1'b1; exp_out = 8'h10; exp_drop = 0;
`else
        exp_oe = 1'b0; exp_out = 8'h00; exp_drop = 1;
`endif
        cmd(LINE2);
        b0 = busy_cnt; d0 = drop_cnt;
        @(negedge clk);
        lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        oe_seen = lcd_dat_oe; out_seen = lcd_dat_out;
        lcd_en = 1'b0;
        repeat (4) @(negedge clk);
        lcd_rw = 1'b0;
        checks++;
        if (oe_seen !== exp_oe || out_seen !== exp_out) begin
            errors++;
            $display("FAIL read_status: got oe=%b out=%02h want oe=%b out=%02h",
                     oe_seen, out_seen, exp_oe, exp_out);
        end
        checks++;
        if (lcd_dat_oe !== 1'b0) begin
            errors++;
            $display("FAIL read_oe_release: got %b want 0", lcd_dat_oe);
        end
        checks++;
        if (drop_cnt - d0 !== exp_drop || busy_cnt - b0 !== 0) begin
            errors++;
            $display("FAIL read_side_effects: got drops=%0d busy=%0d want drops=%0d busy=0",
                     drop_cnt - d0, busy_cnt - b0, exp_drop);
        end
    endtask

    task automatic test_reset_mid_clear;
        int n = 0;
        logic [7:0] d;
        @(negedge clk);
        lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_dat_in = CMD_CLEAR; lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        lcd_en = 1'b0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midclr_start: busy got %b want 1", busy);
        end
        @(negedge clk);            // CLEAR cycle 0
        repeat (20) @(negedge clk); // CLEAR cycle 20
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({disp_on, cursor_on, blink_on, ext_mode, busy, cmd_drop, lcd_dat_oe} !== 7'b0
            || lcd_dat_out !== 8'h00) begin
            errors++;
            $display("FAIL midclr_outputs: got %b/%02h want 0000000/00",
                     {disp_on, cursor_on, blink_on, ext_mode, busy, cmd_drop, lcd_dat_oe}, lcd_dat_out);
        end
        rst_n = 1'b1;
        for (int a = 0; a < 20; a++) model[a] = CLEAR_FILL;
        for (int a = 0; a < 64; a++) begin
            read_byte(6'(a), d);
            checks++;
            if (d !== model[a]) begin
                errors++;
                $display("FAIL midclr_mem[%02h]: got %02h want %02h", a, d, model[a]);
            end
        end
        // Address counter back at 0, increment mode: two writes land at 0x00, 0x01.
        data_wr(8'h77, 6'h00);
        data_wr(8'h78, 6'h01);
        for (int a = 0; a < 2; a++) begin
            read_byte(6'(a), d);
            checks++;
            if (d !== model[a]) begin
                errors++;
                $display("FAIL post_reset_mem[%02h]: got %02h want %02h", a, d, model[a]);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 64; a++) model[a] = 8'h00;
        test_reset;
        test_init;
        test_clear;
        test_row_write;
        test_wrap;
        test_entry_rows;
        test_ext_mode;
        test_read;
        test_reset_mid_clear;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
